// File: rtl/mips_pkg.sv
// Shared definitions for the HI/LO multiply sequencer: state encoding,
// default operand width and the step-counter sizing helper.
package mips_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    function automatic int count_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mult_sequencer_if.sv
// Pipeline-facing signal bundle of the multiply sequencer: decode-stage
// requests and operands toward the unit, read data and status back.
interface mult_sequencer_if
    import mips_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             mult_enable;
    logic             mult_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             sf2reg;
    logic             sfmux_high;
    logic [WIDTH-1:0] rd_data;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output mult_enable, mult_signed, op_a, op_b, sf2reg, sfmux_high,
        input  rd_data, busy, done, stall
    );

    modport slave (
        input  mult_enable, mult_signed, op_a, op_b, sf2reg, sfmux_high,
        output rd_data, busy, done, stall
    );

endinterface

// File: rtl/mult_step.sv
// One radix-2 shift-add iteration: conditionally add the multiplicand into
// the upper accumulator half, then shift {accumulator, multiplier} right.
module mult_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0]   acc,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH:0]   acc_next,
    output logic [WIDTH-1:0]   multiplier_next
);

    logic [WIDTH:0]   upper;
    logic [2*WIDTH:0] added;

    // The top accumulator bit is always zero after a shift, so it can serve
    // as the carry slot of the upper-half addition.
    always_comb begin
        upper = acc[2*WIDTH:WIDTH];
        if (multiplier[0]) begin
            upper = acc[2*WIDTH:WIDTH] + {1'b0, multiplicand};
        end
        added = {upper, acc[WIDTH-1:0]};
        {acc_next, multiplier_next} = {1'b0, added, multiplier[WIDTH-1:1]};
    end

endmodule

// File: rtl/mult_sequencer.sv
// Iterative HI/LO multiply unit: magnitudes go through WIDTH shift-add steps,
// the sign is reapplied on the final edge and HI/LO serve MFHI/MFLO reads.
module mult_sequencer
    import mips_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    mult_sequencer_if.slave  bus
);

    localparam int CNT_W = count_width(WIDTH);
    localparam int ACC_W = 2 * WIDTH + 1;

    seq_state_t state_q;
    seq_state_t state_d;
    logic       start;
    logic       last_step;
    logic       busy;

    logic [WIDTH-1:0]   multiplicand_q;
    logic [WIDTH-1:0]   multiplier_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   count_q;
    logic               sign_q;
    logic               done_q;

    logic [ACC_W-1:0]   acc_next;
    logic [WIDTH-1:0]   multiplier_next;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] product;

    mult_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc             (acc_q),
        .multiplicand    (multiplicand_q),
        .multiplier      (multiplier_q),
        .acc_next        (acc_next),
        .multiplier_next (multiplier_next)
    );

    // Unsigned magnitudes; -2^(WIDTH-1) maps onto its own bit pattern,
    // which is the correct unsigned magnitude.
    always_comb begin
        mag_a = bus.op_a;
        mag_b = bus.op_b;
        if (bus.mult_signed && bus.op_a[WIDTH-1]) begin
            mag_a = ~bus.op_a + WIDTH'(1);
        end
        if (bus.mult_signed && bus.op_b[WIDTH-1]) begin
            mag_b = ~bus.op_b + WIDTH'(1);
        end
        product = acc_next[2*WIDTH-1:0];
        if (sign_q) begin
            product = ~acc_next[2*WIDTH-1:0] + (2*WIDTH)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        last_step = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.mult_enable) begin
                    start   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    last_step = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // HI/LO are only touched on the final step, so reads during RUN keep
    // returning the previous result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            multiplicand_q <= '0;
            multiplier_q   <= '0;
            acc_q          <= '0;
            count_q        <= '0;
            sign_q         <= 1'b0;
            hi_q           <= '0;
            lo_q           <= '0;
            done_q         <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                multiplicand_q <= mag_a;
                multiplier_q   <= mag_b;
                sign_q         <= bus.mult_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                acc_q          <= '0;
                count_q        <= '0;
            end else if (busy) begin
                acc_q        <= acc_next;
                multiplier_q <= multiplier_next;
                count_q      <= count_q + CNT_W'(1);
                if (last_step) begin
                    hi_q   <= product[2*WIDTH-1:WIDTH];
                    lo_q   <= product[WIDTH-1:0];
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done_q;
    assign bus.stall   = busy & (bus.mult_enable | bus.sf2reg);
    assign bus.rd_data = bus.sfmux_high ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer: stimulus queues expected read data,
// a monitor compares whenever a result or an unstalled HI/LO read appears.
module tb_mult_sequencer;

    logic clk;
    logic rst_n;

    mult_sequencer_if #(.WIDTH(32)) bus ();

    mult_sequencer #(
        .WIDTH (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] value;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every completed result or unstalled read consumes one entry.
    always @(negedge clk) begin
        if (bus.done || (bus.sf2reg && !bus.stall)) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got rd_data 0x%0h, expected no output", bus.rd_data);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput(e.name, {32'h0, bus.rd_data}, {32'h0, e.value});
            end
        end
    end

    task automatic waitDone(input string name, output int busyCycles);
        bit ok;
        ok = 1'b0;
        busyCycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
            if (bus.busy) busyCycles++;
        end
        checkOutput({name, "_timeout"}, {63'h0, ok}, 64'h1);
    endtask

    task automatic applyStimulus(input string name, input bit sgn,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expHi, input logic [31:0] expLo,
                                 input bit readHigh, input bit oldRead,
                                 input logic [31:0] oldVal);
        int busyCycles;
        @(posedge clk); #1;
        bus.mult_enable = 1'b1;
        bus.mult_signed = sgn;
        bus.op_a        = a;
        bus.op_b        = b;
        bus.sfmux_high  = readHigh;
        if (oldRead) begin
            expQ.push_back('{{name, "_oldRead"}, oldVal});
            bus.sf2reg = 1'b1;
        end
        @(posedge clk); #1;
        bus.mult_enable = 1'b0;
        bus.sf2reg      = 1'b0;
        expQ.push_back('{{name, "_doneRead"}, readHigh ? expHi : expLo});
        waitDone(name, busyCycles);
        checkOutput({name, "_busyCycles"}, 64'(busyCycles), 64'd32);
        @(posedge clk); #1;
        checkOutput({name, "_donePulse"}, {63'h0, bus.done}, 64'h0);
        expQ.push_back('{{name, "_otherHalf"}, readHigh ? expLo : expHi});
        bus.sf2reg     = 1'b1;
        bus.sfmux_high = ~readHigh;
        @(posedge clk); #1;
        bus.sf2reg = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busyCycles;
        rst_n           = 1'b0;
        bus.mult_enable = 1'b0;
        bus.mult_signed = 1'b0;
        bus.op_a        = '0;
        bus.op_b        = '0;
        bus.sf2reg      = 1'b0;
        bus.sfmux_high  = 1'b0;
        #12;
        checkOutput("reset_busy", {63'h0, bus.busy}, 64'h0);
        checkOutput("reset_done", {63'h0, bus.done}, 64'h0);
        checkOutput("reset_stall", {63'h0, bus.stall}, 64'h0);
        checkOutput("reset_lo", {32'h0, bus.rd_data}, 64'h0);
        bus.sfmux_high = 1'b1;
        #1;
        checkOutput("reset_hi", {32'h0, bus.rd_data}, 64'h0);
        #10 rst_n = 1'b1;

        applyStimulus("multu_7x6", 1'b0, 32'd7, 32'd6, 32'h0, 32'd42, 1'b0, 1'b0, 32'h0);
        applyStimulus("mult_m1x2", 1'b1, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE,
                      1'b0, 1'b1, 32'd42);
        applyStimulus("multu_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1,
                      1'b1, 1'b0, 32'h0);
        applyStimulus("mult_minsq", 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,
                      1'b0, 1'b0, 32'h0);

        // Read HI issued mid-run: stalls until the done cycle, then sees new HI.
        @(posedge clk); #1;
        bus.mult_enable = 1'b1;
        bus.mult_signed = 1'b1;
        bus.op_a        = 32'hFFFFFFFD;
        bus.op_b        = 32'd5;
        @(posedge clk); #1;
        bus.mult_enable = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        expQ.push_back('{"stallRead_hi", 32'hFFFFFFFF});
        bus.sf2reg     = 1'b1;
        bus.sfmux_high = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) break;
            checkOutput("stallRead_stall", {63'h0, bus.stall}, 64'h1);
        end
        checkOutput("stallRead_doneStall", {63'h0, bus.stall}, 64'h0);
        checkOutput("stallRead_done", {63'h0, bus.done}, 64'h1);
        @(posedge clk); #1;
        expQ.push_back('{"stallRead_lo", 32'hFFFFFFF1});
        bus.sfmux_high = 1'b0;
        @(posedge clk); #1;
        bus.sf2reg = 1'b0;

        // Second request during RUN is held, then accepted in the done cycle.
        @(posedge clk); #1;
        bus.mult_enable = 1'b1;
        bus.mult_signed = 1'b0;
        bus.op_a        = 32'h12345678;
        bus.op_b        = 32'h10;
        bus.sfmux_high  = 1'b0;
        @(posedge clk); #1;
        expQ.push_back('{"b2b_first_lo", 32'h23456780});
        bus.mult_signed = 1'b1;
        bus.op_a        = 32'h7FFFFFFF;
        bus.op_b        = 32'hFFFFFFFF;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) break;
            checkOutput("b2b_stall", {63'h0, bus.stall}, 64'h1);
        end
        checkOutput("b2b_doneStall", {63'h0, bus.stall}, 64'h0);
        @(posedge clk); #1;
        bus.mult_enable = 1'b0;
        bus.sfmux_high  = 1'b1;
        expQ.push_back('{"b2b_second_hi", 32'hFFFFFFFF});
        waitDone("b2b_second", busyCycles);
        checkOutput("b2b_second_busyCycles", 64'(busyCycles), 64'd32);
        @(posedge clk); #1;
        expQ.push_back('{"b2b_second_lo", 32'h80000001});
        bus.sf2reg     = 1'b1;
        bus.sfmux_high = 1'b0;
        @(posedge clk); #1;
        bus.sf2reg = 1'b0;

        // Asynchronous reset after step 10, away from any clock edge.
        @(posedge clk); #1;
        bus.mult_enable = 1'b1;
        bus.mult_signed = 1'b0;
        bus.op_a        = 32'd100;
        bus.op_b        = 32'd100;
        @(posedge clk); #1;
        bus.mult_enable = 1'b0;
        bus.sf2reg      = 1'b1;
        bus.sfmux_high  = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        checkOutput("preReset_stall", {63'h0, bus.stall}, 64'h1);
        checkOutput("preReset_hi", {32'h0, bus.rd_data}, 64'hFFFFFFFF);
        expQ.push_back('{"inReset_hiRead", 32'h0});
        rst_n = 1'b0;
        #1;
        checkOutput("inReset_busy", {63'h0, bus.busy}, 64'h0);
        checkOutput("inReset_done", {63'h0, bus.done}, 64'h0);
        checkOutput("inReset_stall", {63'h0, bus.stall}, 64'h0);
        checkOutput("inReset_rd", {32'h0, bus.rd_data}, 64'h0);
        @(posedge clk); #1;
        bus.sf2reg = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("postReset_busy", {63'h0, bus.busy}, 64'h0);
        expQ.push_back('{"postReset_lo", 32'h0});
        bus.sf2reg     = 1'b1;
        bus.sfmux_high = 1'b0;
        @(posedge clk); #1;
        bus.sf2reg = 1'b0;
        applyStimulus("multu_3x5", 1'b0, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0, 1'b0, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("queueEmpty", 64'(expQ.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Iterative multiply sequencer for the MIPS core's HI/LO unit. It accepts a multiply request from the decode stage (qualified by `mult_enable`) and runs a radix-2 shift-add over `WIDTH` cycles. It holds the 64-bit result in HI/LO and serves `mfhi`/`mflo` reads (`sf2reg`, with `sfmux_high` selecting HI or LO). While a multiply is in flight it raises `stall` toward the pipeline for any multiply or HI/LO read.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `mult_enable`  in  1: multiply request (MULT/MULTU in the stage).
- `mult_signed`  in  1: 1 = MULT (two's complement), 0 = MULTU.
- `op_a`  in  WIDTH: rs operand.
- `op_b`  in  WIDTH: rt operand.
- `sf2reg`  in  1: HI/LO read request (MFHI/MFLO).
- `sfmux_high`  in  1: 1 = read HI, 0 = read LO.
- `rd_data`  out  WIDTH: selected HI or LO.
- `busy`  out  1: multiply in progress.
- `done`  out  1: one-cycle pulse when HI/LO have just been written.
- `stall`  out  1: pipeline hold request.

## Operation
- States: IDLE, RUN.
- IDLE -> RUN on `mult_enable`=1. The start edge latches:
  - |op_a| into multiplicand and |op_b| into multiplier. Magnitudes apply only when `mult_signed`=1; otherwise raw values.
  - result sign = `mult_signed` & (op_a[MSB] ^ op_b[MSB]).
  - accumulator (2*WIDTH+1 bits) cleared; step counter cleared to 0.
- RUN, each edge:
  - if multiplier[0]=1, add multiplicand into accumulator[2*WIDTH-1:WIDTH], carry into bit 2*WIDTH.
  - shift {accumulator, multiplier} right by 1; counter increments.
- RUN -> IDLE on the edge where the counter reaches WIDTH-1. On that edge:
  - HI:LO is written with the 2*WIDTH-bit product, two's-complement negated if the result sign is 1.
  - `done` is set for the next cycle.
- Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) as unsigned; no overflow, because the product fits in 2*WIDTH bits.
- `rd_data` = `sfmux_high` ? HI : LO, combinational from registers. HI/LO are unchanged during RUN until the final edge.
- `stall` = `busy` & (`mult_enable` | `sf2reg`), combinational. The pipeline holds the requesting instruction and its operands stable while stalled.
- `mult_enable` in RUN is not accepted; it is stalled, and no restart occurs.
- `mult_enable` in the `done` cycle (state IDLE) is accepted normally, back-to-back.
- `sf2reg` in the `done` cycle returns the new result without stall.
- Simultaneous `mult_enable` and `sf2reg` in IDLE: the read returns the old HI/LO in that cycle and the multiply starts on the same edge.

## Timing
- Start edge E0; RUN occupies edges E1..E_WIDTH. HI/LO valid and `done`=1 in the cycle after E_WIDTH.
- Start-to-result latency is WIDTH+1 edges.
- `busy`=1 for exactly WIDTH cycles, starting the cycle after E0.
- Reset (async, any state) clears the following, immediately and independent of `clk`:
  - state to IDLE;
  - HI, LO, accumulator, counter and sign to 0;
  - `busy`=0, `done`=0, `stall`=0, `rd_data`=0.
- Reset mid-RUN discards the operation; HI/LO read 0 afterward.

## Structure
- Shared package (`mips_pkg`): state enum {IDLE, RUN}, default `WIDTH`=32, counter width $clog2(WIDTH).
- Sub-module `mult_step`, combinational: one conditional add plus right shift of {carry, accumulator, multiplier}. The sequencer instantiates it once and registers its output.
- The sign-magnitude conversion and final negation stay in the top block.

## Test plan
- Reset, then MULTU 7 x 6 -> after 33 edges LO=42, HI=0. `done` pulses for one cycle; `busy` was high for exactly 32 cycles.
- MULT 0xFFFFFFFF x 0x00000002 (-1 x 2) -> HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
- `sf2reg`=1, `sfmux_high`=1 issued 5 cycles after a start:
  - `stall`=1 until `done`;
  - in the `done` cycle `stall`=0 and `rd_data`=new HI.
- Second `mult_enable` during RUN -> `stall`=1 and the first result is unchanged. Then the back-to-back start in the `done` cycle completes 33 edges later with the correct second product.
- Deassert `rst_n` at step 10 of a run, with no clock edge:
  - outputs go to 0 immediately;
  - after release, `busy`=0 and HI/LO=0;
  - a new 3 x 5 yields LO=15.
